// File: rtl/decode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the decode_ctrl slice: opcodes,
//               register-bank write-control codes, FSM state encodings,
//               program-counter select codes and instruction field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RC_MSB  = 27;
    localparam int RC_LSB  = 24;
    localparam int RA_MSB  = 23;
    localparam int RA_LSB  = 20;
    localparam int RB_MSB  = 19;
    localparam int RB_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcodes; 6..14 are undefined
    localparam logic [3:0] OP_ALU  = 4'd0;
    localparam logic [3:0] OP_LIL  = 4'd1;
    localparam logic [3:0] OP_LIH  = 4'd2;
    localparam logic [3:0] OP_JAL  = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_NOP  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Register-bank write-control codes
    localparam logic [2:0] WR_FULL = 3'b000;
    localparam logic [2:0] WR_LO   = 3'b001;
    localparam logic [2:0] WR_HI   = 3'b010;
    localparam logic [2:0] WR_LINK = 3'b011;
    localparam logic [2:0] WR_NONE = 3'b111;

    // FSM state encodings
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB     = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    // Program-counter update select
    localparam logic [1:0] PC_HOLD   = 2'd0;
    localparam logic [1:0] PC_INC    = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    // Write-control code produced by each opcode during write-back
    function automatic logic [2:0] wr_code(input logic [3:0] op);
        case (op)
            OP_ALU:  wr_code = WR_FULL;
            OP_LIL:  wr_code = WR_LO;
            OP_LIH:  wr_code = WR_HI;
            OP_JAL:  wr_code = WR_LINK;
            default: wr_code = WR_NONE;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        is_illegal = (op > OP_NOP) && (op != OP_HALT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_if
// Description : Bundles the instruction-fetch handshake, the ALU hookup and
//               the register-bank control bus of decode_ctrl.
//               master : the controller (drives fetch request and bank ctrl)
//               slave  : memory / ALU / register bank side
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_ctrl_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [3:0]  alu_op;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [3:0]  reg_c;
    logic [2:0]  reg_ctrl;
    logic [31:0] reg_data;
    logic [31:0] reg_pc;
    logic        halted;
    logic        illegal;

    modport master (
        output instr_req, instr_addr, alu_op, reg_a, reg_b, reg_c,
               reg_ctrl, reg_data, reg_pc, halted, illegal,
        input  instr_valid, instr_data, alu_result, alu_zero
    );

    modport slave (
        input  instr_req, instr_addr, alu_op, reg_a, reg_b, reg_c,
               reg_ctrl, reg_data, reg_pc, halted, illegal,
        output instr_valid, instr_data, alu_result, alu_zero
    );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter register with next-PC selection.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sel_i        : PC_HOLD / PC_INC / PC_JUMP / PC_BRANCH
//   imm16_i      : immediate used for jump and branch targets
//   pc_o         : current program counter
//   pc_plus4_o   : pc + 4 (link value)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sel_i,
    input  logic [15:0] imm16_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_branch_tgt;

    assign pc_plus4_o   = pc_q + 32'd4;
    // JAL is absolute word address; BEQ is a signed word offset from pc+4
    assign w_jump_tgt   = {14'b0, imm16_i, 2'b00};
    assign w_branch_tgt = pc_plus4_o + {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_INC:    pc_d = pc_plus4_o;
            PC_JUMP:   pc_d = w_jump_tgt;
            PC_BRANCH: pc_d = w_branch_tgt;
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl
// Description : Multi-cycle fetch/decode/execute/write-back controller in
//               front of the register bank. Owns the PC, resolves JAL/BEQ.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : decode_ctrl_if.master (fetch handshake, ALU, bank control)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_ctrl_if.master bus
);
    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        br_q, br_d;
    logic        illegal_q, illegal_d;

    logic [3:0]  w_opcode;
    logic [15:0] w_imm16;
    logic [1:0]  w_pc_sel;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;

    assign w_opcode = ir_q[OPC_MSB:OPC_LSB];
    assign w_imm16  = ir_q[IMM_MSB:IMM_LSB];

    pc_unit #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_i      (w_pc_sel),
        .imm16_i    (w_imm16),
        .pc_o       (w_pc),
        .pc_plus4_o (w_pc_plus4)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        br_d      = br_q;
        illegal_d = illegal_q;
        w_pc_sel  = PC_HOLD;
        case (state_q)
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                br_d = bus.alu_zero;
                // flag raised here so it is already visible during WB
                if (is_illegal(w_opcode)) illegal_d = 1'b1;
                state_d = (w_opcode == OP_HALT) ? ST_HALT : ST_WB;
            end
            ST_WB: begin
                if (w_opcode == OP_JAL)              w_pc_sel = PC_JUMP;
                else if (w_opcode == OP_BEQ && br_q) w_pc_sel = PC_BRANCH;
                else                                 w_pc_sel = PC_INC;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            ir_q      <= 32'h0;
            br_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            br_q      <= br_d;
            illegal_q <= illegal_d;
        end
    end

    // Bank control is decoded combinationally from state, so an asynchronous
    // reset forces reg_ctrl to "none" without waiting for a clock edge.
    assign bus.instr_req  = (state_q == ST_FETCH);
    assign bus.instr_addr = w_pc;
    assign bus.alu_op     = ir_q[3:0];
    assign bus.reg_a      = ir_q[RA_MSB:RA_LSB];
    assign bus.reg_b      = ir_q[RB_MSB:RB_LSB];
    assign bus.reg_c      = ir_q[RC_MSB:RC_LSB];
    assign bus.reg_ctrl   = (state_q == ST_WB) ? wr_code(w_opcode) : WR_NONE;
    assign bus.reg_pc     = w_pc_plus4;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.illegal    = illegal_q;

    always_comb begin
        bus.reg_data = 32'h0;
        if (state_q == ST_WB) begin
            case (w_opcode)
                OP_ALU:        bus.reg_data = bus.alu_result;
                OP_LIL,OP_LIH: bus.reg_data = {16'h0, w_imm16};
                OP_JAL:        bus.reg_data = w_pc_plus4;
                default:       bus.reg_data = 32'h0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/decode_ctrl.md
# decode_ctrl

Multi-cycle fetch/decode/write-back controller that sits directly upstream of the register bank. It fetches 32-bit instructions over a request/valid handshake and decodes them. It drives the bank's read addresses, write address, write-control code, write data and link PC. It also owns the program counter, and resolves jumps and conditional branches using the ALU's zero flag.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous reset, active-low
- instr_req  out  1  fetch request, high only in FETCH
- instr_addr  out  32  byte address of the requested instruction (= pc)
- instr_valid  in  1  instr_data valid this cycle; sampled only in FETCH
- instr_data  in  32  instruction word
- alu_result  in  32  ALU result for R-type write-back
- alu_zero  in  1  ALU zero flag, used by BEQ
- alu_op  out  4  ALU operation = IR[3:0]
- reg_a, reg_b  out  4 each  bank read addresses = IR[23:20], IR[19:16]
- reg_c  out  4  bank write address = IR[27:24]
- reg_ctrl  out  3  bank write control: 000 full, 001 low half, 010 high half, 011 link to r15, 111 none
- reg_data  out  32  bank write data
- reg_pc  out  32  link value = pc + 4
- halted  out  1  HALT executed; sticky until reset
- illegal  out  1  undefined opcode seen; sticky until reset

## Operation
- Instruction format: [31:28] opcode, [27:24] rc, [23:20] ra, [19:16] rb, [15:0] imm16.
- Opcodes and write-back behaviour:
  - 0 ALU: reg_ctrl=000, reg_data=alu_result.
  - 1 LIL: reg_ctrl=001, reg_data={16'h0, imm16}.
  - 2 LIH: reg_ctrl=010, reg_data={16'h0, imm16}.
  - 3 JAL: reg_ctrl=011; pc <= {14'b0, imm16, 2'b00}.
  - 4 BEQ: no write; if alu_zero, pc <= pc+4+({{14{imm16[15]}}, imm16, 2'b00}).
  - 5 NOP: no write.
  - 15 HALT: enter HALT.
  - 6–14: treated as NOP and set illegal.
- pc <= pc+4 at WB unless a jump or taken branch occurs. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- FSM states:
  - FETCH: instr_req=1; wait for instr_valid, then latch IR and go to DECODE. A request stays high across stalls.
  - DECODE: reg_a/reg_b are driven from IR, and the bank outputs settle. Go to EXEC.
  - EXEC: the ALU evaluates and alu_zero is sampled into a branch flag. Go to WB, or to HALT if opcode=15.
  - WB: reg_ctrl carries the decoded code for exactly this one cycle; pc updates; go to FETCH.
  - HALT: terminal; instr_req=0, reg_ctrl=111, halted=1.
- reg_ctrl=111 in every state except WB. This guarantees at most one bank write per instruction.
- instr_valid outside FETCH is ignored. IR is held stable from DECODE through WB.
- Reset values: pc=RESET_PC, state=FETCH, IR=0, reg_ctrl=111, reg_data=0, instr_req=1 (on first post-reset cycle), halted=0, illegal=0.
- Reset mid-instruction: the instruction is abandoned and reg_ctrl goes to 111 asynchronously. No partial write is issued.

## Timing
- 4 cycles per instruction when instr_valid is high in the first FETCH cycle. Each cycle of stall adds one.
- IR is captured on the clk edge where state=FETCH and instr_valid=1.
- The bank write takes effect on the rising edge that ends WB. reg_c, reg_data and reg_pc are stable for the entire WB cycle.
- instr_addr for the next fetch reflects the updated pc in the first FETCH cycle after WB.
- alu_zero must be valid by the end of EXEC; alu_result must be valid by the end of WB.

## Structure
- Shared package ctrl_pkg:
  - opcode constants OP_ALU..OP_HALT
  - reg_ctrl codes WR_FULL, WR_LO, WR_HI, WR_LINK, WR_NONE
  - FSM state enum
  - instruction field positions
- One sub-module pc_unit: holds pc and computes pc+4, the jump target and the branch target, with a select input from the FSM.
- FSM and decode live in the top.

## Test plan
- Reset and fetch:
  - Stimulus: release rst_n with RESET_PC=0; present LIL r3, 16'hBEEF with instr_valid in cycle 1.
  - Required response: instr_addr=0; reg_ctrl=001, reg_c=3, reg_data=16'hBEEF only in cycle 4; next instr_addr=4.
- Fetch stall:
  - Stimulus: hold instr_valid low for 3 cycles.
  - Required response: instr_req stays 1; reg_ctrl stays 111; instruction completes in 7 cycles.
- JAL at pc=8 with imm16=16'h0010:
  - Required response: reg_ctrl=011, reg_pc=12 during WB; next instr_addr=0x40.
- BEQ with imm16=16'hFFFF at pc=0x20:
  - Stimulus: alu_zero=1 in EXEC.
  - Required response: next address 0x20; repeat with alu_zero=0 and the next address is 0x24.
- Illegal opcode 7, then HALT:
  - Required response: illegal=1 with no write; after HALT, halted=1, instr_req=0 permanently.
- Reset mid-instruction:
  - Stimulus: assert rst_n low during WB of an ALU op.
  - Required response: reg_ctrl drops to 111 immediately, pc returns to RESET_PC, and no write is observed.
